// File: rtl/ps2_poly_note_mapper_if.sv
// ---------------------------------------------------------------------------
// ps2_poly_note_mapper_if
// Bundle between the PS/2 byte receiver side and the polyphonic note mapper.
//   code_valid   : one-cycle strobe, code holds a received scan-code byte
//   code         : PS/2 set-2 scan-code byte
//   sustain      : sustain pedal level (1 = hold)
//   voice_note   : per slot {sharp, octave[1:0], degree[2:0]}, slot i at [6i+5:6i]
//   voice_active : per slot sounding flag
//   evt_valid    : one-cycle pulse per note event
//   evt_on       : 1 = note-on, 0 = note-off (qualified by evt_valid)
//   evt_note     : note of the last event
//   overflow     : one-cycle pulse when a note was stolen or dropped
// master = byte source / consumer side, slave = the mapper.
// ---------------------------------------------------------------------------
interface ps2_poly_note_mapper_if #(
  parameter int NUM_VOICES = 4
);
  logic                      code_valid;
  logic [7:0]                code;
  logic                      sustain;
  logic [6*NUM_VOICES-1:0]   voice_note;
  logic [NUM_VOICES-1:0]     voice_active;
  logic                      evt_valid;
  logic                      evt_on;
  logic [5:0]                evt_note;
  logic                      overflow;

  modport master (
    output code_valid, code, sustain,
    input  voice_note, voice_active, evt_valid, evt_on, evt_note, overflow
  );

  modport slave (
    input  code_valid, code, sustain,
    output voice_note, voice_active, evt_valid, evt_on, evt_note, overflow
  );
endinterface

// File: rtl/ps2_poly_note_mapper.sv
// ---------------------------------------------------------------------------
// ps2_poly_note_mapper
// Parses PS/2 set-2 make/break/extended byte sequences, maps piano keys to
// 6-bit note codes and allocates them to NUM_VOICES voice slots, with
// typematic-repeat suppression, sustain pedal and optional voice stealing.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ps2_poly_note_mapper_if.slave (byte input, sustain, slot state,
//           note events, overflow pulse); all outputs are registered.
// ---------------------------------------------------------------------------
module ps2_poly_note_mapper #(
  parameter int NUM_VOICES   = 4,
  parameter bit ENABLE_STEAL = 1'b1,
  parameter int STEAL_PTR_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ps2_poly_note_mapper_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  state_t                        state_r, state_nx_s;
  logic                          make_s, brk_s;
  logic [5:0]                    key_s;
  logic                          sustain_q_r, sus_fall_s;

  logic [NUM_VOICES-1:0][5:0]    note_r, note_nx_s;
  logic [NUM_VOICES-1:0]         active_r, active_nx_s;
  logic [NUM_VOICES-1:0]         held_r, held_nx_s;
  logic [NUM_VOICES-1:0]         match_s, free_oh_s, steal_oh_s;
  logic [STEAL_PTR_W-1:0]        steal_ptr_r, steal_ptr_nx_s;
  logic                          evt_valid_r, evt_valid_nx_s;
  logic                          evt_on_r, evt_on_nx_s;
  logic [5:0]                    evt_note_r, evt_note_nx_s;
  logic                          overflow_r, overflow_nx_s;

  // Scan code to {sharp, octave, degree}; 0 marks an unmapped code.
  function automatic logic [5:0] map_key(input logic [7:0] c);
    logic [5:0] k;
    case (c)
      8'h58: k = 6'h01;  8'h1C: k = 6'h02;  8'h1B: k = 6'h03;  8'h23: k = 6'h04;
      8'h2B: k = 6'h05;  8'h34: k = 6'h06;  8'h33: k = 6'h07;
      8'h3B: k = 6'h09;  8'h42: k = 6'h0A;  8'h4B: k = 6'h0B;  8'h4C: k = 6'h0C;
      8'h52: k = 6'h0D;  8'h5A: k = 6'h0E;  8'h6B: k = 6'h0F;
      8'h12: k = 6'h21;  8'h1A: k = 6'h22;  8'h22: k = 6'h23;  8'h21: k = 6'h24;
      8'h2A: k = 6'h25;  8'h32: k = 6'h26;  8'h31: k = 6'h27;
      default: k = 6'h00;
    endcase
    return k;
  endfunction

  assign key_s      = map_key(bus.code);
  assign sus_fall_s = sustain_q_r & ~bus.sustain;

  // Parser state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Parser next-state decode; advances only on code_valid.
  always_comb begin
    state_nx_s = state_r;
    if (bus.code_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.code == 8'hF0)      state_nx_s = ST_BRK;
          else if (bus.code == 8'hE0) state_nx_s = ST_EXT;
          else                        state_nx_s = ST_IDLE;
        end
        ST_BRK:     state_nx_s = ST_IDLE;
        ST_EXT: begin
          if (bus.code == 8'hF0) state_nx_s = ST_EXT_BRK;
          else                   state_nx_s = ST_IDLE;
        end
        ST_EXT_BRK: state_nx_s = ST_IDLE;
        default:    state_nx_s = ST_IDLE;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Parser outputs: make/break requests for the current byte.
  always_comb begin
    make_s = 1'b0;
    brk_s  = 1'b0;
    if (bus.code_valid) begin
      case (state_r)
        ST_IDLE: make_s = (bus.code != 8'hF0) && (bus.code != 8'hE0);
        ST_BRK:  brk_s  = 1'b1;
        default: begin
          make_s = 1'b0;
          brk_s  = 1'b0;
        end
      endcase
    end else begin
      make_s = 1'b0;
      brk_s  = 1'b0;
    end
  end

  // Voice allocation: sustain release first, then make/break on the result.
  always_comb begin
    note_nx_s      = note_r;
    held_nx_s      = held_r;
    steal_ptr_nx_s = steal_ptr_r;
    evt_valid_nx_s = 1'b0;
    evt_on_nx_s    = evt_on_r;
    evt_note_nx_s  = evt_note_r;
    overflow_nx_s  = 1'b0;
    match_s        = '0;
    free_oh_s      = '0;
    steal_oh_s     = '0;

    // A released-but-sounding slot (held=0) stops when the pedal lifts.
    if (sus_fall_s) active_nx_s = active_r & held_r;
    else            active_nx_s = active_r;

    for (int i = 0; i < NUM_VOICES; i++) begin
      match_s[i]    = active_nx_s[i] && (note_r[i] == key_s);
      steal_oh_s[i] = (STEAL_PTR_W'(i) == steal_ptr_r);
    end
    // Descending scan so the lowest free index wins.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!active_nx_s[i]) begin
        free_oh_s    = '0;
        free_oh_s[i] = 1'b1;
      end else begin
        free_oh_s = free_oh_s;
      end
    end

    if (make_s && (key_s != 6'h00)) begin
      if (|match_s) begin
        held_nx_s = held_nx_s | match_s;
      end else if ((|free_oh_s) || ENABLE_STEAL) begin
        if (!(|free_oh_s)) begin
          free_oh_s     = steal_oh_s;
          overflow_nx_s = 1'b1;
          if (steal_ptr_r == STEAL_PTR_W'(NUM_VOICES - 1)) steal_ptr_nx_s = '0;
          else                                             steal_ptr_nx_s = steal_ptr_r + STEAL_PTR_W'(1);
        end else begin
          steal_ptr_nx_s = steal_ptr_r;
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (free_oh_s[i]) note_nx_s[i] = key_s;
          else              note_nx_s[i] = note_nx_s[i];
        end
        active_nx_s    = active_nx_s | free_oh_s;
        held_nx_s      = held_nx_s | free_oh_s;
        evt_valid_nx_s = 1'b1;
        evt_on_nx_s    = 1'b1;
        evt_note_nx_s  = key_s;
      end else begin
        overflow_nx_s = 1'b1;
      end
    end else if (brk_s && (key_s != 6'h00) && (|match_s)) begin
      held_nx_s = held_nx_s & ~match_s;
      if (!bus.sustain) begin
        active_nx_s    = active_nx_s & ~match_s;
        evt_valid_nx_s = 1'b1;
        evt_on_nx_s    = 1'b0;
        evt_note_nx_s  = key_s;
      end else begin
        evt_valid_nx_s = 1'b0;
      end
    end else begin
      evt_valid_nx_s = 1'b0;
    end
  end

  // Slot state, pedal history and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_r      <= '0;
      active_r    <= '0;
      held_r      <= '0;
      steal_ptr_r <= '0;
      sustain_q_r <= 1'b0;
      evt_valid_r <= 1'b0;
      evt_on_r    <= 1'b0;
      evt_note_r  <= 6'h00;
      overflow_r  <= 1'b0;
    end else begin
      note_r      <= note_nx_s;
      active_r    <= active_nx_s;
      held_r      <= held_nx_s;
      steal_ptr_r <= steal_ptr_nx_s;
      sustain_q_r <= bus.sustain;
      evt_valid_r <= evt_valid_nx_s;
      evt_on_r    <= evt_on_nx_s;
      evt_note_r  <= evt_note_nx_s;
      overflow_r  <= overflow_nx_s;
    end
  end

  assign bus.voice_note   = note_r;
  assign bus.voice_active = active_r;
  assign bus.evt_valid    = evt_valid_r;
  assign bus.evt_on       = evt_on_r;
  assign bus.evt_note     = evt_note_r;
  assign bus.overflow     = overflow_r;

endmodule

// File: tb/tb_ps2_poly_note_mapper.sv
// ---------------------------------------------------------------------------
// tb_ps2_poly_note_mapper
// Two instances (stealing on / off) driven with identical byte streams and
// compared every cycle against a behavioural model built from the key table,
// a prefix queue for the make/break/extended grammar and per-slot arrays.
// ---------------------------------------------------------------------------
module tb_ps2_poly_note_mapper;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ps2_poly_note_mapper_if #(.NUM_VOICES(NV)) bus_st ();
  ps2_poly_note_mapper_if #(.NUM_VOICES(NV)) bus_dr ();

  ps2_poly_note_mapper #(.NUM_VOICES(NV), .ENABLE_STEAL(1'b1), .STEAL_PTR_W(3)) dut_st (
    .clk(clk), .rst_n(rst_n), .bus(bus_st));
  ps2_poly_note_mapper #(.NUM_VOICES(NV), .ENABLE_STEAL(1'b0), .STEAL_PTR_W(3)) dut_dr (
    .clk(clk), .rst_n(rst_n), .bus(bus_dr));

  // ---------------- reference model (index 0: stealing, 1: dropping) ------
  logic [7:0] nat0 [7] = '{8'h58, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33};
  logic [7:0] nat1 [7] = '{8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52, 8'h5A, 8'h6B};
  logic [7:0] shp  [7] = '{8'h12, 8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31};

  logic [7:0] pfx [$];
  logic [5:0] m_note [2][NV];
  bit         m_act  [2][NV];
  bit         m_held [2][NV];
  int         m_sp [2];
  bit         m_ev_v [2], m_ev_on [2], m_ov [2];
  logic [5:0] m_ev_note [2];
  bit         prev_sus;

  function automatic logic [5:0] keymap(input logic [7:0] c);
    for (int i = 0; i < 7; i++) begin
      if (c == nat0[i]) return 6'(i + 1);
      if (c == nat1[i]) return 6'(8 + i + 1);
      if (c == shp[i])  return 6'(32 + i + 1);
    end
    return 6'd0;
  endfunction

  task automatic model_reset();
    pfx.delete();
    prev_sus = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_sp[m] = 0; m_ev_v[m] = 0; m_ev_on[m] = 0; m_ov[m] = 0; m_ev_note[m] = 6'd0;
      for (int s = 0; s < NV; s++) begin
        m_note[m][s] = 6'd0; m_act[m][s] = 0; m_held[m][s] = 0;
      end
    end
  endtask

  task automatic model_step(input bit v, input logic [7:0] c, input bit sus);
    bit mk, bk;
    logic [5:0] key;
    int hit, free;
    mk = 0; bk = 0;
    if (v) begin
      if (pfx.size() == 0) begin
        if (c == 8'hF0 || c == 8'hE0) pfx.push_back(c);
        else mk = 1;
      end else if (pfx.size() == 1 && pfx[0] == 8'hF0) begin
        bk = 1; pfx.delete();
      end else if (pfx.size() == 1 && pfx[0] == 8'hE0 && c == 8'hF0) begin
        pfx.push_back(c);
      end else begin
        pfx.delete();
      end
    end
    key = keymap(c);
    for (int m = 0; m < 2; m++) begin
      m_ev_v[m] = 0; m_ov[m] = 0;
      if (prev_sus && !sus)
        for (int s = 0; s < NV; s++) if (m_act[m][s] && !m_held[m][s]) m_act[m][s] = 0;
      if ((mk || bk) && key != 6'd0) begin
        hit = -1;
        for (int s = 0; s < NV; s++) if (m_act[m][s] && m_note[m][s] == key) hit = s;
        if (mk) begin
          if (hit >= 0) m_held[m][hit] = 1;
          else begin
            free = -1;
            for (int s = NV - 1; s >= 0; s--) if (!m_act[m][s]) free = s;
            if (free < 0) begin
              m_ov[m] = 1;
              if (m == 0) begin free = m_sp[0]; m_sp[0] = (m_sp[0] + 1) % NV; end
            end
            if (free >= 0) begin
              m_note[m][free] = key; m_act[m][free] = 1; m_held[m][free] = 1;
              m_ev_v[m] = 1; m_ev_on[m] = 1; m_ev_note[m] = key;
            end
          end
        end else if (hit >= 0) begin
          m_held[m][hit] = 0;
          if (!sus) begin
            m_act[m][hit] = 0;
            m_ev_v[m] = 1; m_ev_on[m] = 0; m_ev_note[m] = key;
          end
        end
      end
    end
    prev_sus = sus;
  endtask

  function automatic logic [36:0] expv(input int m);
    logic [23:0] n;
    logic [3:0]  a;
    for (int s = 0; s < NV; s++) begin n[6*s +: 6] = m_note[m][s]; a[s] = m_act[m][s]; end
    return {n, a, m_ev_v[m], m_ev_on[m], m_ev_note[m], m_ov[m]};
  endfunction

  function automatic logic [36:0] obs(input int m);
    if (m == 0)
      return {bus_st.voice_note, bus_st.voice_active, bus_st.evt_valid, bus_st.evt_on,
              bus_st.evt_note, bus_st.overflow};
    return {bus_dr.voice_note, bus_dr.voice_active, bus_dr.evt_valid, bus_dr.evt_on,
            bus_dr.evt_note, bus_dr.overflow};
  endfunction

  // ---------------- stimulus helpers (drive only, no checking) ------------
  task automatic drive(input bit v, input logic [7:0] c, input bit sus);
    bus_st.code_valid = v; bus_st.code = c; bus_st.sustain = sus;
    bus_dr.code_valid = v; bus_dr.code = c; bus_dr.sustain = sus;
  endtask

  // Called at a negedge; returns at the following negedge with model updated.
  task automatic cycle(input bit v, input logic [7:0] c, input bit sus);
    drive(v, c, sus);
    @(negedge clk);
    model_step(v, c, sus);
    drive(1'b0, 8'h00, sus);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- tests -------------------------------------------------
  task automatic test_reset();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs(m) !== 37'd0) begin
        failures++;
        $display("FAIL reset dut%0d: got %h want %h", m, obs(m), 37'd0);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] seq [8] = '{8'h1C, 8'hF0, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h3B, 8'h12};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, seq[i], 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs(m) !== expv(m)) begin
          failures++;
          $display("FAIL basic dut%0d step%0d: got %h want %h", m, i, obs(m), expv(m));
        end
      end
      if (i == 0) begin
        checks++;
        if ({bus_st.voice_active, bus_st.evt_valid, bus_st.evt_on, bus_st.evt_note} !== {4'b0001, 1'b1, 1'b1, 6'h02}) begin
          failures++;
          $display("FAIL basic_first_on: got act=%b evt=%b/%b/%h want 0001 1/1/02",
                   bus_st.voice_active, bus_st.evt_valid, bus_st.evt_on, bus_st.evt_note);
        end
      end
      if (i == 7) begin
        checks++;
        if ({bus_st.voice_active, bus_st.voice_note[17:0]} !== {4'b0111, 6'h21, 6'h09, 6'h02}) begin
          failures++;
          $display("FAIL basic_slots: got act=%b notes=%h want 0111 21/09/02",
                   bus_st.voice_active, bus_st.voice_note[17:0]);
        end
      end
    end
  endtask

  task automatic test_steal();
    logic [7:0] seq [6] = '{8'h58, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, seq[i], 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs(m) !== expv(m)) begin
          failures++;
          $display("FAIL steal dut%0d step%0d: got %h want %h", m, i, obs(m), expv(m));
        end
      end
      if (i == 4) begin
        checks++;
        if ({bus_st.voice_note[5:0], bus_st.overflow, bus_dr.voice_note[5:0], bus_dr.overflow, bus_dr.evt_valid}
            !== {6'h05, 1'b1, 6'h01, 1'b1, 1'b0}) begin
          failures++;
          $display("FAIL steal_first: got st=%h/%b dr=%h/%b/%b want 05/1 01/1/0",
                   bus_st.voice_note[5:0], bus_st.overflow, bus_dr.voice_note[5:0],
                   bus_dr.overflow, bus_dr.evt_valid);
        end
      end
    end
    checks++;
    if (bus_st.voice_note[11:6] !== 6'h06) begin
      failures++;
      $display("FAIL steal_second: got slot1=%h want 06", bus_st.voice_note[11:6]);
    end
  endtask

  task automatic test_sustain();
    logic [7:0] c   [13] = '{8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00,
                             8'h1C, 8'h1B, 8'hF0, 8'h1C, 8'h00, 8'hF0, 8'h1B, 8'h1C};
    bit         v   [13] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 1, 1, 1};
    bit         sus [13] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 1, 0, 1};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      cycle(v[i], c[i], sus[i]);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs(m) !== expv(m)) begin
          failures++;
          $display("FAIL sustain dut%0d step%0d: got %h want %h", m, i, obs(m), expv(m));
        end
      end
    end
  endtask

  task automatic test_extended();
    logic [7:0] seq [11] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'hF0, 8'h1C,
                             8'hF0, 8'hF0, 8'h1B};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, seq[i], 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs(m) !== expv(m)) begin
          failures++;
          $display("FAIL extended dut%0d step%0d: got %h want %h", m, i, obs(m), expv(m));
        end
      end
    end
    checks++;
    if ({bus_st.evt_valid, bus_st.evt_on, bus_st.evt_note} !== {1'b1, 1'b1, 6'h03}) begin
      failures++;
      $display("FAIL extended_then_make: got %b/%b/%h want 1/1/03",
               bus_st.evt_valid, bus_st.evt_on, bus_st.evt_note);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1'b1, 8'h58, 1'b0);
    cycle(1'b1, 8'h1B, 1'b1);
    cycle(1'b1, 8'hF0, 1'b1);
    do_reset();
    cycle(1'b1, 8'h1C, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs(m) !== expv(m)) begin
        failures++;
        $display("FAIL reset_mid dut%0d: got %h want %h", m, obs(m), expv(m));
      end
    end
    checks++;
    if ({bus_st.voice_active, bus_st.voice_note, bus_st.evt_valid, bus_st.evt_on, bus_st.evt_note}
        !== {4'b0001, 24'h000002, 1'b1, 1'b1, 6'h02}) begin
      failures++;
      $display("FAIL reset_mid_make: got act=%b notes=%h evt=%b/%b/%h want 0001 000002 1/1/02",
               bus_st.voice_active, bus_st.voice_note, bus_st.evt_valid, bus_st.evt_on, bus_st.evt_note);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [8] = '{8'h58, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h3B, 8'h12, 8'h31};
    bit sus;
    int r;
    logic [7:0] c;
    do_reset();
    sus = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) sus = ~sus;
      r = $urandom_range(0, 9);
      if (r <= 2)      c = 8'hF0;
      else if (r == 3) c = 8'hE0;
      else if (r == 4) c = 8'($urandom);
      else             c = pool[$urandom_range(0, 7)];
      cycle($urandom_range(0, 7) != 0, c, sus);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs(m) !== expv(m)) begin
          failures++;
          $display("FAIL random dut%0d cyc%0d code=%h: got %h want %h", m, i, c, obs(m), expv(m));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    model_reset();
    test_reset();
    test_basic();
    test_steal();
    test_sustain();
    test_extended();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
